// File: rtl/addr_data_q_arb.sv
// Two-requester round-robin arbiter in front of a shared first-word-fall-through
// queue that keeps each address/data pair together in acceptance order.
module addr_data_q_arb #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          last_q, last_d;

    logic          grant0, grant1;
    logic          push0, push1, push, pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    // Round-robin grant: a contested cycle goes to the requester not served last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    // Ready looks only at registered full, so a pop cannot open a slot for the same cycle.
    assign req0_ready = !rst && !full_q && grant0;
    assign req1_ready = !rst && !full_q && grant1;

    assign push0     = req0_valid && req0_ready;
    assign push1     = req1_valid && req1_ready;
    assign push      = push0 || push1;
    assign pop       = out_valid && out_ready;
    assign push_addr = push1 ? req1_addr : req0_addr;
    assign push_data = push1 ? req1_data : req0_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            last_d   = push1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // NOTE: the storage array is deliberately not reset; valid data is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            last_q   <= last_d;
        end
    end

    assign out_valid = !empty_q;
    assign out_addr  = empty_q ? '0 : addr_mem[rd_ptr_q];
    assign out_data  = empty_q ? '0 : data_mem[rd_ptr_q];
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;

endmodule

// File: tb/tb_addr_data_q_arb.sv
// Self-checking bench for addr_data_q_arb: a negedge monitor keeps a scoreboard of
// accepted pairs and compares every pop; scenario tasks check flags and grants.
module tb_addr_data_q_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid, out_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready, out_valid, empty, full;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     count;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    pop_cnt = 0;
    pair_t exp_q[$];
    int    grant_log[$];

    addr_data_q_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge, so mid-cycle values are what the next edge sees.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pair_t exp;
                pop_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_underflow: got %h/%h with nothing expected", out_addr, out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_addr, out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL pop_order: got %h/%h expected %h/%h",
                                 out_addr, out_data, exp.addr, exp.data);
                    end
                end
            end
            if (!out_valid) begin
                n_tests++;
                if (out_addr !== '0 || out_data !== '0) begin
                    n_fail++;
                    $display("FAIL empty_head_zero: got %h/%h expected 0/0", out_addr, out_data);
                end
            end
            if (req0_valid && req0_ready && req1_ready) begin
                n_fail++;
                $display("FAIL double_grant: both ready high");
            end
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{addr: req0_addr, data: req0_data});
                grant_log.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{addr: req1_addr, data: req1_data});
                grant_log.push_back(1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        idle_inputs();
        out_ready = 1'b1;
        while (!empty && guard < 4 * DEPTH) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        tick();
        n_tests++;
        if (empty !== 1'b1 || count !== '0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: empty=%b count=%0d pending=%0d expected 1/0/0",
                     empty, count, exp_q.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid = 1'b1;
        req0_addr  = 32'h100;
        for (int i = 0; i < 5; i++) begin
            req0_data = 32'(i);
            tick();
        end
        n_tests++;
        if (count !== CW'(5)) begin
            n_fail++;
            $display("FAIL reset_prefill_count: got %0d expected 5", count);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
            out_addr !== '0 || out_data !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b ov=%b out=%h/%h rdy=%b%b expected 0,1,0,0,0/0,00",
                     count, empty, full, out_valid, out_addr, out_data, req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b1;
        req1_addr  = 32'h200;
        req1_data  = 32'h22;
        req0_data  = 32'h11;
        n_tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_held: got %b%b expected 00", req0_ready, req1_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_single_requester();
        idle_inputs();
        req0_valid = 1'b1;
        req0_addr  = 32'd1;
        req0_data  = 32'd2;
        repeat (10) tick();
        req0_valid = 1'b0;
        n_tests++;
        if (count !== CW'(10) || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fill: count=%0d empty=%b expected 10/0", count, empty);
        end
        pop_cnt   = 0;
        out_ready = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        n_tests++;
        if (pop_cnt != 10 || empty !== 1'b1 || count !== '0) begin
            n_fail++;
            $display("FAIL single_drain: pops=%0d empty=%b count=%0d expected 10/1/0", pop_cnt, empty, count);
        end
    endtask

    task automatic test_contention();
        idle_inputs();
        req0_addr  = 32'hA;
        req0_data  = 32'h1;
        req1_addr  = 32'hB;
        req1_data  = 32'h2;
        out_ready  = 1'b1;
        req1_valid = 1'b1;
        tick();
        grant_log.delete();
        pop_cnt    = 0;
        req0_valid = 1'b1;
        repeat (8) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_tests++;
        if (grant_log.size() != 8) begin
            n_fail++;
            $display("FAIL contention_grants: got %0d grants expected 8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (grant_log[i] != (i % 2)) begin
                    n_fail++;
                    $display("FAIL contention_order[%0d]: got %0d expected %0d", i, grant_log[i], i % 2);
                end
            end
        end
        n_tests++;
        if (pop_cnt != 8 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL contention_throughput: pops=%0d count=%0d expected 8/1", pop_cnt, count);
        end
        drain();
    endtask

    task automatic test_full();
        idle_inputs();
        req0_valid = 1'b1;
        req0_addr  = 32'h5000;
        for (int i = 0; i < DEPTH; i++) begin
            req0_data = 32'(i + 100);
            tick();
        end
        req1_valid = 1'b1;
        req1_addr  = 32'h6000;
        req1_data  = 32'h77;
        #1;
        n_tests++;
        if (full !== 1'b1 || count !== CW'(DEPTH) || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: full=%b count=%0d rdy=%b%b expected 1/%0d/00",
                     full, count, req0_ready, req1_ready, DEPTH);
        end
        req0_valid = 1'b0;
        out_ready  = 1'b1;
        #1;
        n_tests++;
        if (req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_blocks_push: req1_ready=%b expected 0", req1_ready);
        end
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (count !== CW'(DEPTH - 1) || full !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_pop: count=%0d full=%b req1_ready=%b expected %0d/0/1",
                     count, full, req1_ready, DEPTH - 1);
        end
        tick();
        req1_valid = 1'b0;
        n_tests++;
        if (count !== CW'(DEPTH) || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_refill: count=%0d full=%b expected %0d/1", count, full, DEPTH);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        req1_valid = 1'b1;
        req1_addr  = 32'hC0;
        for (int i = 0; i < 3; i++) begin
            req1_data = 32'(i);
            tick();
        end
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req0_addr = 32'h1000 + 32'(i);
            req0_data = $urandom;
            tick();
            n_tests++;
            if (count !== CW'(3)) begin
                n_fail++;
                $display("FAIL back_to_back_count[%0d]: got %0d expected 3", i, count);
            end
        end
        drain();
    endtask

    task automatic test_empty_ready();
        idle_inputs();
        out_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 32'd7;
        req0_data  = 32'd9;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL empty_no_passthrough: out_valid=%b count=%0d expected 0/0", out_valid, count);
        end
        tick();
        req0_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== 32'd7 || out_data !== 32'd9 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL empty_push_head: ov=%b out=%0d/%0d count=%0d expected 1, 7/9, 1",
                     out_valid, out_addr, out_data, count);
        end
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (count !== '0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop_back: count=%0d empty=%b expected 0/1", count, empty);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req0_addr = '0;
        req0_data = '0;
        req1_addr = '0;
        req1_data = '0;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_single_requester();
        test_contention();
        test_full();
        test_back_to_back();
        test_empty_ready();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
